// File: rtl/menu_ctrl.sv
// menu_ctrl: browse/edit menu controller for the amplifier front panel.
// Encoder events are registered for one cycle and applied on the following
// edge. Settings and the LCD refresh handshake are also held in registers.
module menu_ctrl #(
    parameter int VOL_MAX      = 31,
    parameter int VOL_DEFAULT  = 16,
    parameter int TONE_MAX     = 15,
    parameter int TONE_DEFAULT = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] action,
    input  logic       lcd_ready,
    output logic       lcd_req,
    output logic [1:0] menu_sel,
    output logic       edit_mode,
    output logic [4:0] volume,
    output logic [3:0] bass,
    output logic [3:0] treble,
    output logic       mute,
    output logic       param_changed
);

    typedef enum logic {BROWSE = 1'b0, EDIT = 1'b1} state_t;

    localparam logic [1:0] ACT_LEFT  = 2'd1;
    localparam logic [1:0] ACT_RIGHT = 2'd2;
    localparam logic [1:0] ACT_PRESS = 2'd3;

    localparam logic [1:0] ITEM_VOL    = 2'd0;
    localparam logic [1:0] ITEM_BASS   = 2'd1;
    localparam logic [1:0] ITEM_TREBLE = 2'd2;
    localparam logic [1:0] ITEM_MUTE   = 2'd3;

    localparam logic [4:0] VMAX  = 5'(VOL_MAX);
    localparam logic [4:0] VDEF  = 5'(VOL_DEFAULT);
    localparam logic [3:0] TMAX  = 4'(TONE_MAX);
    localparam logic [3:0] TDEF  = 4'(TONE_DEFAULT);

    // One saturating step, computed one bit wider so that overflow and
    // underflow are visible and can be clamped instead of wrapping.
    function automatic logic [4:0] step5(input logic [4:0] v, input logic up,
                                         input logic [4:0] max);
        logic [5:0] w;
        if (up) begin
            w = {1'b0, v} + 6'd1;
            if (w > {1'b0, max}) w = {1'b0, max};
        end else begin
            w = {1'b0, v} - 6'd1;
            if (w[5]) w = 6'd0;
        end
        return w[4:0];
    endfunction

    function automatic logic [3:0] step4(input logic [3:0] v, input logic up,
                                         input logic [3:0] max);
        logic [4:0] w;
        if (up) begin
            w = {1'b0, v} + 5'd1;
            if (w > {1'b0, max}) w = {1'b0, max};
        end else begin
            w = {1'b0, v} - 5'd1;
            if (w[4]) w = 5'd0;
        end
        return w[3:0];
    endfunction

    logic       ev_vld_q;
    logic [1:0] ev_act_q;
    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [4:0] vol_q, vol_d;
    logic [3:0] bass_q, bass_d;
    logic [3:0] treb_q, treb_d;
    logic       mute_q, mute_d;
    logic       pchg_q, pchg_d;
    logic       req_q, req_d;
    logic       dirty_q, dirty_d;
    logic       param_chg, disp_chg, up;

    // Capture encoder events; "none" actions are dropped here.
    always_ff @(posedge clk) begin
        if (rst) begin
            ev_vld_q <= 1'b0;
            ev_act_q <= 2'd0;
        end else begin
            ev_vld_q <= start && (action != 2'd0);
            ev_act_q <= action;
        end
    end

    // State and settings registers; lcd_req comes up high so the first
    // screen gets drawn after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BROWSE;
            sel_q   <= ITEM_VOL;
            vol_q   <= VDEF;
            bass_q  <= TDEF;
            treb_q  <= TDEF;
            mute_q  <= 1'b0;
            pchg_q  <= 1'b0;
            req_q   <= 1'b1;
            dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            vol_q   <= vol_d;
            bass_q  <= bass_d;
            treb_q  <= treb_d;
            mute_q  <= mute_d;
            pchg_q  <= pchg_d;
            req_q   <= req_d;
            dirty_q <= dirty_d;
        end
    end

    // Next state: apply the registered event, then derive change flags
    // and the LCD request/dirty update from them.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        vol_d   = vol_q;
        bass_d  = bass_q;
        treb_d  = treb_q;
        mute_d  = mute_q;
        up      = (ev_act_q == ACT_RIGHT);

        if (ev_vld_q) begin
            case (state_q)
                BROWSE: begin
                    case (ev_act_q)
                        ACT_LEFT:  sel_d = sel_q - 2'd1;
                        ACT_RIGHT: sel_d = sel_q + 2'd1;
                        ACT_PRESS: begin
                            if (sel_q == ITEM_MUTE) mute_d  = ~mute_q;
                            else                    state_d = EDIT;
                        end
                        default: ;
                    endcase
                end
                EDIT: begin
                    if (ev_act_q == ACT_PRESS) begin
                        state_d = BROWSE;
                    end else begin
                        case (sel_q)
                            ITEM_VOL:    vol_d  = step5(vol_q, up, VMAX);
                            ITEM_BASS:   bass_d = step4(bass_q, up, TMAX);
                            ITEM_TREBLE: treb_d = step4(treb_q, up, TMAX);
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end

        param_chg = (vol_d != vol_q) || (bass_d != bass_q) ||
                    (treb_d != treb_q) || (mute_d != mute_q);
        disp_chg  = param_chg || (sel_d != sel_q) || (state_d != state_q);
        pchg_d    = param_chg;

        // A pending request only ever falls; anything that changes meanwhile
        // is remembered in dirty and re-requested once the line is low.
        req_d   = req_q;
        dirty_d = dirty_q;
        if (req_q) begin
            if (lcd_ready) req_d = 1'b0;
            dirty_d = dirty_q || disp_chg;
        end else if (dirty_q || disp_chg) begin
            req_d   = 1'b1;
            dirty_d = 1'b0;
        end
    end

    assign lcd_req       = req_q;
    assign menu_sel      = sel_q;
    assign edit_mode     = (state_q == EDIT);
    assign volume        = vol_q;
    assign bass          = bass_q;
    assign treble        = treb_q;
    assign mute          = mute_q;
    assign param_changed = pchg_q;

endmodule
